mixcolumns_iter: RTL and testbench



---
 rtl/mixcolumns_iter.sv | 149 ++++++++++++++
 tb/tb_mixcolumns_iter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mixcolumns_iter.sv
// Iterative AES MixColumns / InvMixColumns engine with valid/ready handshakes.
// COLS_PER_CYCLE columns are transformed per clock by a shared xtime array;
// a full state takes 4 / COLS_PER_CYCLE passes in RUN before DONE.
module mixcolumns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int NUM_PASSES = 4 / COLS_PER_CYCLE;
  localparam int PASS_W     = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r;
  logic [PASS_W-1:0]   pass_r;
  logic                mode_r;
  logic [127:0]        work_r;
  logic [127:0]        work_nxt_s;
  logic                accept_s;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through MixColumns (inv = 0) or InvMixColumns (inv = 1).
  // x1/x2/x3 are the chained xtimes of each byte, shared by both directions.
  function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
    logic [7:0]  a  [4];
    logic [7:0]  x1 [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x3 [4];
    logic [1:0]  i0;
    logic [1:0]  i1;
    logic [1:0]  i2;
    logic [1:0]  i3;
    logic [7:0]  fwd;
    logic [7:0]  rev;
    logic [31:0] res;
    res = 32'h0;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31 - 8*r -: 8];
      x1[r] = xtime(a[r]);
      x2[r] = xtime(x1[r]);
      x3[r] = xtime(x2[r]);
    end
    for (int r = 0; r < 4; r++) begin
      i0  = 2'(r);
      i1  = i0 + 2'd1;
      i2  = i0 + 2'd2;
      i3  = i0 + 2'd3;
      // 02.a0 ^ 03.a1 ^ a2 ^ a3
      fwd = x1[i0] ^ (x1[i1] ^ a[i1]) ^ a[i2] ^ a[i3];
      // 0e.a0 ^ 0b.a1 ^ 0d.a2 ^ 09.a3
      rev = (x3[i0] ^ x2[i0] ^ x1[i0]) ^
            (x3[i1] ^ x1[i1] ^ a[i1]) ^
            (x3[i2] ^ x2[i2] ^ a[i2]) ^
            (x3[i3] ^ a[i3]);
      res[31 - 8*r -: 8] = inv ? rev : fwd;
    end
    return res;
  endfunction

  // Handshake and status outputs are decoded straight from the state register.
  always_comb begin
    in_ready  = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready);
    out_valid = (state_r == ST_DONE);
    busy      = (state_r == ST_RUN);
    out_data  = work_r;
    accept_s  = in_valid & in_ready;
  end

  // Working register with the columns of the current pass replaced in place.
  always_comb begin
    work_nxt_s = work_r;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      work_nxt_s[127 - 32*(int'(pass_r)*COLS_PER_CYCLE + j) -: 32] =
        mix_column(work_r[127 - 32*(int'(pass_r)*COLS_PER_CYCLE + j) -: 32], mode_r);
    end
  end

  // Control FSM plus working state, mode and pass counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      pass_r  <= '0;
      mode_r  <= 1'b0;
      work_r  <= 128'h0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            work_r  <= in_data;
            mode_r  <= in_mode;
            pass_r  <= '0;
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          work_r <= work_nxt_s;
          pass_r <= (pass_r == LAST_PASS) ? '0 : pass_r + PASS_W'(1);
          if (pass_r == LAST_PASS) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          // A new input can only be accepted here together with the output handshake.
          if (accept_s) begin
            work_r  <= in_data;
            mode_r  <= in_mode;
            pass_r  <= '0;
            state_r <= ST_RUN;
          end else if (out_ready) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mixcolumns_iter.sv
// Bench for mixcolumns_iter: three instances (1, 2 and 4 columns per cycle),
// a transaction-level reference model and one per-cycle compare process.
module tb_mixcolumns_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid  [3];
  logic         in_mode   [3];
  logic         out_ready [3];
  logic [127:0] in_data   [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         busy      [3];
  logic [127:0] out_data  [3];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // reference-model state, owned by the compare process
  bit           has      [3] = '{default: 1'b0};
  logic [127:0] exp_data [3];
  int           exp_due  [3];
  int           res_cnt  [3] = '{default: 0};
  int           last_hs  [3] = '{default: -1};
  bit           streaming = 1'b0;

  localparam logic [127:0] V_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

  mixcolumns_iter #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_mode(in_mode[0]), .in_data(in_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));
  mixcolumns_iter #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_mode(in_mode[1]), .in_data(in_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));
  mixcolumns_iter #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_mode(in_mode[2]), .in_data(in_data[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2]));

  function automatic int npass(input int i);
    return 4 >> i;
  endfunction

  // generic GF(2^8) product, shift-and-add
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // whole-state reference: out[c][r] = sum_k coef[k] * in[c][(r+k) mod 4]
  function automatic logic [127:0] mix_ref(input logic [127:0] d, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] o;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(d[127 - 32*c - 8*((r + k) % 4) -: 8], coef[k]);
        o[127 - 32*c - 8*r -: 8] = acc;
      end
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: predicts each instance's outputs from accepted transactions.
  always @(negedge clk) begin : monitor
    bit ev;
    bit eir;
    for (int i = 0; i < 3; i++) begin
      if (!streaming) last_hs[i] = -1;
      if (!rst_n) begin
        chk($sformatf("rst out_valid[%0d]", i), out_valid[i], 1'b0);
        chk($sformatf("rst in_ready[%0d]", i),  in_ready[i],  1'b1);
        chk($sformatf("rst busy[%0d]", i),      busy[i],      1'b0);
        chk($sformatf("rst out_data[%0d]", i),  out_data[i],  128'h0);
        has[i] = 1'b0;
      end else begin
        ev  = has[i] && (cyc >= exp_due[i]);
        eir = !has[i] || (ev && out_ready[i]);
        chk($sformatf("out_valid[%0d]", i), out_valid[i], ev);
        chk($sformatf("busy[%0d]", i),      busy[i],      has[i] && (cyc < exp_due[i]));
        chk($sformatf("in_ready[%0d]", i),  in_ready[i],  eir);
        if (ev) chk($sformatf("out_data[%0d]", i), out_data[i], exp_data[i]);
        if (ev && out_ready[i]) begin
          has[i] = 1'b0;
          res_cnt[i]++;
          // accept rides on the output handshake, then N passes follow
          if (streaming && last_hs[i] >= 0)
            chk($sformatf("stream gap[%0d]", i), cyc - last_hs[i], npass(i) + 1);
          last_hs[i] = cyc;
        end
        if (in_valid[i] && eir) begin
          has[i]      = 1'b1;
          exp_data[i] = mix_ref(in_data[i], in_mode[i]);
          exp_due[i]  = cyc + 1 + npass(i);
        end
      end
    end
  end

  task automatic run_one(input int i, input logic [127:0] d, input logic m,
                         output logic [127:0] y, output int lat);
    bit acc;
    int k;
    @(posedge clk); #1;
    in_valid[i] = 1'b1; in_data[i] = d; in_mode[i] = m; out_ready[i] = 1'b1;
    acc = 1'b0;
    k   = 0;
    while (!acc && k < 20) begin
      #1 acc = in_ready[i];
      @(posedge clk); #1;
      k++;
    end
    in_valid[i] = 1'b0;
    in_mode[i]  = ~m;
    if (!acc) chk("accept timeout", 1'b0, 1'b1);
    lat = 0;
    while (!out_valid[i] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid[i]) chk("result timeout", 1'b0, 1'b1);
    y = out_data[i];
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [127:0] y;
    logic [127:0] z;
    logic [127:0] x;
    logic [127:0] t_in;
    logic [127:0] t_out;
    int           lat;
    int           c0;

    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; in_mode[i] = 1'b0; out_ready[i] = 1'b0; in_data[i] = 128'h0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("post-reset out_valid", out_valid[0], 1'b0);
    chk("post-reset in_ready",  in_ready[0],  1'b1);
    chk("post-reset out_data",  out_data[0],  128'h0);

    // pin the reference model to hand-computed vectors
    chk("model fwd", mix_ref(V_IN, 1'b0), V_OUT);
    chk("model inv", mix_ref(V_OUT, 1'b1), V_IN);
    chk("model d4",  mix_ref({4{32'hd4d4d4d5}}, 1'b0), {4{32'hd5d5d7d6}});

    // known vectors and latency on every width
    for (int i = 0; i < 3; i++) begin
      run_one(i, V_IN, 1'b0, y, lat);
      chk($sformatf("fwd vector[%0d]", i), y, V_OUT);
      chk($sformatf("fwd latency[%0d]", i), lat, npass(i));
      run_one(i, V_OUT, 1'b1, y, lat);
      chk($sformatf("inv vector[%0d]", i), y, V_IN);
      chk($sformatf("inv latency[%0d]", i), lat, npass(i));
    end

    // single-column vectors in every column position
    for (int p = 0; p < 4; p++) begin
      t_in  = 128'hd4d4d4d5;
      t_out = 128'hd5d5d7d6;
      run_one(p % 3, t_in << (32*(3 - p)), 1'b0, y, lat);
      chk($sformatf("d4 col%0d", p), y, t_out << (32*(3 - p)));
      t_in  = 128'h2d26314c;
      t_out = 128'h4d7ebdf8;
      run_one(p % 3, t_in << (32*(3 - p)), 1'b0, y, lat);
      chk($sformatf("2d col%0d", p), y, t_out << (32*(3 - p)));
    end

    // backpressure: DONE held with out_ready low, in_valid ignored
    @(posedge clk); #1;
    in_valid[0] = 1'b1; in_data[0] = V_IN; in_mode[0] = 1'b0; out_ready[0] = 1'b0;
    @(posedge clk); #1;
    in_data[0] = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    in_mode[0] = 1'b1;
    lat = 0;
    while (!out_valid[0] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp reach done", out_valid[0], 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      in_data[0] = {$urandom, $urandom, $urandom, $urandom};
      in_mode[0] = ~in_mode[0];
      #1;
      chk("bp out_data held", out_data[0], V_OUT);
      chk("bp in_ready low",  in_ready[0], 1'b0);
    end
    in_data[0] = V_OUT; in_mode[0] = 1'b1; out_ready[0] = 1'b1;
    #1 chk("bp in_ready with out_ready", in_ready[0], 1'b1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    chk("bp no bubble busy", busy[0], 1'b1);
    chk("bp out_valid fell", out_valid[0], 1'b0);
    lat = 0;
    while (!out_valid[0] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp second result", out_data[0], V_IN);
    repeat (3) @(posedge clk);

    // streaming with alternating mode, out_ready held high
    #1;
    streaming   = 1'b1;
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    c0 = res_cnt[0];
    for (int k = 0; k < 40; k++) begin
      in_data[0] = {$urandom, $urandom, $urandom, $urandom};
      in_mode[0] = ~in_mode[0];
      @(posedge clk); #1;
    end
    chk("stream result count", res_cnt[0] - c0, 7);
    in_valid[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1 streaming = 1'b0;

    // asynchronous reset during pass 2
    @(posedge clk); #1;
    in_valid[0] = 1'b1; in_data[0] = {$urandom, $urandom, $urandom, $urandom}; in_mode[0] = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort out_valid", out_valid[0], 1'b0);
    chk("abort out_data",  out_data[0],  128'h0);
    chk("abort in_ready",  in_ready[0],  1'b1);
    chk("abort busy",      busy[0],      1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_one(0, {4{32'h2d26314c}}, 1'b0, y, lat);
    chk("after abort result",  y,   {4{32'h4d7ebdf8}});
    chk("after abort latency", lat, 4);

    // round trip on random states across all widths
    for (int n = 0; n < 1000; n++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      run_one(n % 3, x, 1'b0, y, lat);
      run_one(n % 3, y, 1'b1, z, lat);
      chk($sformatf("round trip %0d", n), z, x);
    end

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
